// File: rtl/serial_subtractor_if.sv
// Start/ready handshake plus result bundle for the bit-serial subtractor.
// The master side issues operands; the slave side returns the difference and flags.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ready_o;
  logic [WIDTH-1:0] d_o;
  logic             borrow_o;
  logic             ovf_o;
  logic             valid_o;

  modport master (
    output start_i, a_i, b_i,
    input  ready_o, d_o, borrow_o, ovf_o, valid_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output ready_o, d_o, borrow_o, ovf_o, valid_o
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B, one bit per clock, LSB first, through a single
// full-subtractor cell and a borrow flop. Results are held until the next operation.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             bin;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;

  logic             ready_r;
  logic             valid_r;
  logic [WIDTH-1:0] d_r;
  logic             borrow_r;
  logic             ovf_r;

  logic             diff_p0;
  logic             bout_p0;
  logic [WIDTH-1:0] res_nxt;
  logic             last_bit;

  // Returns {borrow_out, difference} for one bit position.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bi);
    logic d;
    logic bo;
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
    return {bo, d};
  endfunction

  always_comb begin
    {bout_p0, diff_p0} = full_sub(a_sh[0], b_sh[0], bin);
    res_nxt            = {diff_p0, res_sh[WIDTH-1:1]};
    last_bit           = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      bin      <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      d_r      <= '0;
      borrow_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_r <= 1'b0;
          if (bus.start_i) begin
            a_sh    <= bus.a_i;
            b_sh    <= bus.b_i;
            res_sh  <= '0;
            bin     <= 1'b0;
            cnt     <= '0;
            a_msb   <= bus.a_i[WIDTH-1];
            b_msb   <= bus.b_i[WIDTH-1];
            ready_r <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          bin    <= bout_p0;
          cnt    <= cnt + CNT_W'(1);
          // Published outputs change only here, so they stay stable throughout RUN.
          if (last_bit) begin
            d_r      <= res_nxt;
            borrow_r <= bout_p0;
            ovf_r    <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
            valid_r  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o  = ready_r;
  assign bus.valid_o  = valid_r;
  assign bus.d_o      = d_r;
  assign bus.borrow_o = borrow_r;
  assign bus.ovf_o    = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4: reset, arithmetic vectors,
// latency/pulse width, start held through RUN/DONE, and mid-operation reset.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, then count edges until valid_o; checks latency,
  // results, pulse width and return to ready.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_d, input logic exp_bo, input logic exp_ov);
    int k;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check({tag, "_busy"}, 32'(bus.ready_o), 32'd0);
    k = 0;
    while (!bus.valid_o && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'd4);
    check({tag, "_d"}, 32'(bus.d_o), 32'(exp_d));
    check({tag, "_borrow"}, 32'(bus.borrow_o), 32'(exp_bo));
    check({tag, "_ovf"}, 32'(bus.ovf_o), 32'(exp_ov));
    check({tag, "_ready_done"}, 32'(bus.ready_o), 32'd0);
    tick();
    check({tag, "_pulse_w"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.ready_o), 32'd1);
    check({tag, "_hold_d"}, 32'(bus.d_o), 32'(exp_d));
  endtask

  initial begin
    int k;
    n_cmp = 0;
    n_err = 0;

    // Reset with garbage inputs and start high: reset must win.
    rst         = 1'b1;
    bus.start_i = 1'b1;
    bus.a_i     = 4'hD;
    bus.b_i     = 4'h6;
    tick();
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_d", 32'(bus.d_o), 32'd0);
    check("rst_borrow", 32'(bus.borrow_o), 32'd0);
    check("rst_ovf", 32'(bus.ovf_o), 32'd0);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    tick();

    // Signed views: 9=-7, 3=3 -> -10 overflows; 3-(-7)=10 overflows.
    run_op("v9m3", 4'd9, 4'd3, 4'd6, 1'b0, 1'b1);
    run_op("v3m9", 4'd3, 4'd9, 4'hA, 1'b1, 1'b1);
    run_op("v0m1", 4'd0, 4'd1, 4'hF, 1'b1, 1'b0);
    run_op("v8m1", 4'd8, 4'd1, 4'd7, 1'b0, 1'b1);
    run_op("v6m6", 4'd6, 4'd6, 4'd0, 1'b0, 1'b0);

    // start_i held high; operands scrambled during RUN/DONE.
    bus.a_i     = 4'd5;
    bus.b_i     = 4'd2;
    bus.start_i = 1'b1;
    tick();
    k = 0;
    while (!bus.valid_o && k < 20) begin
      bus.a_i = 4'($urandom_range(0, 15));
      bus.b_i = 4'($urandom_range(0, 15));
      if (k == 1) check("held_d_in_run", 32'(bus.d_o), 32'd0);
      tick();
      k++;
    end
    check("bb1_latency", 32'(k), 32'd4);
    check("bb1_d", 32'(bus.d_o), 32'd3);
    check("bb1_borrow", 32'(bus.borrow_o), 32'd0);
    bus.a_i = 4'd7;
    bus.b_i = 4'd2;
    k = 0;
    tick();
    k++;
    check("bb_idle_ready", 32'(bus.ready_o), 32'd1);
    tick();
    k++;
    check("bb_accepted", 32'(bus.ready_o), 32'd0);
    while (!bus.valid_o && k < 30) begin
      bus.a_i = 4'($urandom_range(0, 15));
      bus.b_i = 4'($urandom_range(0, 15));
      tick();
      k++;
    end
    check("bb_period", 32'(k), 32'd6);
    check("bb2_d", 32'(bus.d_o), 32'd5);
    check("bb2_ovf", 32'(bus.ovf_o), 32'd0);
    bus.start_i = 1'b0;
    tick();
    tick();

    // Reset on the edge processing bit 2 of 5-2.
    bus.a_i     = 4'd5;
    bus.b_i     = 4'd2;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", 32'(bus.ready_o), 32'd1);
    check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
    check("mid_rst_d", 32'(bus.d_o), 32'd0);
    check("mid_rst_borrow", 32'(bus.borrow_o), 32'd0);
    check("mid_rst_ovf", 32'(bus.ovf_o), 32'd0);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.valid_o) k++;
      tick();
    end
    check("mid_rst_no_valid", 32'(k), 32'd0);
    run_op("after_rst", 4'd5, 4'd2, 4'd3, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
